// File: rtl/ctrl_seq.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM control sequencer for the accumulator CPU.
// Optional build macro ILLEGAL_TRAP_EN: undefined opcodes trap to HALT via sticky illegal_op.
module ctrl_seq #(
  parameter int unsigned IR_W        = 16,
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [IR_W-1:0]  ir_in,
  input  logic             mem_ack,
  input  logic             acc_zero,
  input  logic             acc_sign,
  output logic             mem_req,
  output logic             mem_we,
  output logic             ir_load,
  output logic             pc_inc,
  output logic             pc_load,
  output logic [1:0]       sel_A,
  output logic [2:0]       sel_B,
  output logic             CI,
  output logic             acc_update,
  output logic             busy,
  output logic             halted,
  output logic             err_timeout,
  output logic [CNT_W-1:0] instr_cnt
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic             illegal_op
`endif
);

  localparam int unsigned OP_W   = 6;
  localparam int unsigned WAIT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam logic              WD_EN    = (TIMEOUT_CYC > 0);

  localparam logic [1:0] A_DI = 2'd0, A_ACC = 2'd1, A_PC = 2'd2, A_X = 2'd3;
  localparam logic [2:0] B_DI = 3'd0, B_NDI = 3'd1, B_NACC = 3'd2, B_C = 3'd3,
                         B_ZERO = 3'd4, B_X = 3'd7;

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, HALT} state_t;

  state_t            state_q, state_d;
  logic [IR_W-1:0]   ir_q;
  logic [WAIT_W-1:0] wait_q;
  logic [OP_W-1:0]   opcode;
  logic              op_mem, op_halt, op_defined;
  logic              cnt_inc, wait_clr, wait_inc, set_to, set_ill;

  assign opcode     = ir_q[IR_W-1 -: OP_W];
  assign op_mem     = (opcode == 6'b101000) || (opcode == 6'b101001);
  assign op_halt    = (opcode == 6'b111111);
  assign op_defined = !opcode[5] || (opcode == 6'b101100) || (opcode == 6'b110000) ||
                      (opcode == 6'b110010) || (opcode == 6'b110001);
  assign busy       = (state_q != IDLE) && (state_q != HALT);
  assign halted     = (state_q == HALT);

  generate
    if (IR_W > OP_W) begin : g_ir_low
      logic unused_ir_low;
      assign unused_ir_low = ^ir_q[IR_W-OP_W-1:0];
    end
  endgenerate

  // Next-state and control decode
  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    ir_load    = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    sel_A      = A_X;
    sel_B      = B_X;
    CI         = 1'b0;
    acc_update = 1'b0;
    cnt_inc    = 1'b0;
    wait_clr   = 1'b0;
    wait_inc   = 1'b0;
    set_to     = 1'b0;
    set_ill    = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d  = FETCH;
        wait_clr = 1'b1;
      end
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_load = 1'b1;
          pc_inc  = 1'b1;
          state_d = DECODE;
        end else if (WD_EN && (wait_q == WAIT_LIM)) begin
          set_to  = 1'b1;
          state_d = HALT;
        end else begin
          wait_inc = 1'b1;
        end
      end
      DECODE: begin
        if (op_mem) begin
          state_d  = MEM;
          wait_clr = 1'b1;
        end else if (op_halt) begin
          state_d = HALT;
          cnt_inc = 1'b1;
`ifdef ILLEGAL_TRAP_EN
        end else if (!op_defined) begin
          state_d = HALT;
          set_ill = 1'b1;
`endif
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        casez (opcode)
          6'b000???: begin sel_A = A_DI;  sel_B = B_ZERO; acc_update = !opcode[2]; end
          6'b001???: begin sel_A = A_ACC; sel_B = B_DI;   acc_update = !opcode[2]; end
          6'b010???: begin sel_A = A_ACC; sel_B = B_NDI;  CI = 1'b1; acc_update = !opcode[2]; end
          6'b011???: begin sel_A = A_DI;  sel_B = B_NACC; CI = 1'b1; acc_update = !opcode[2]; end
          6'b101100: begin sel_A = A_ACC; sel_B = B_ZERO; pc_load = 1'b1; end
          6'b110000: begin sel_A = A_PC;  sel_B = B_C;    pc_load = 1'b1; end
          6'b110010: begin sel_A = A_PC;  sel_B = B_C;    pc_load = acc_zero; end
          6'b110001: begin sel_A = A_PC;  sel_B = B_C;    pc_load = acc_sign; end
          default: ;
        endcase
        cnt_inc  = 1'b1;
        state_d  = FETCH;
        wait_clr = 1'b1;
      end
      MEM: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        sel_A   = A_ACC;
        sel_B   = B_ZERO;
        if (mem_ack) begin
          cnt_inc  = 1'b1;
          state_d  = FETCH;
          wait_clr = 1'b1;
        end else if (WD_EN && (wait_q == WAIT_LIM)) begin
          set_to  = 1'b1;
          state_d = HALT;
        end else begin
          wait_inc = 1'b1;
        end
      end
      HALT: ;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ir_q        <= '0;
      wait_q      <= '0;
      instr_cnt   <= '0;
      err_timeout <= 1'b0;
    end else begin
      state_q <= state_d;
      if (ir_load)       ir_q   <= ir_in;
      if (wait_clr)      wait_q <= '0;
      else if (wait_inc) wait_q <= wait_q + WAIT_W'(1);
      if (cnt_inc)       instr_cnt <= instr_cnt + CNT_W'(1);
      if (set_to)        err_timeout <= 1'b1;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          illegal_op <= 1'b0;
    else if (set_ill) illegal_op <= 1'b1;
  end
`else
  logic unused_trap;
  assign unused_trap = set_ill ^ op_defined;
`endif

endmodule

// File: tb/tb_ctrl_seq.sv
// Directed bench for ctrl_seq with an 8-cycle watchdog; handles both ILLEGAL_TRAP_EN builds.
module tb_ctrl_seq;
  logic        clk = 1'b0;
  logic        rst, start, mem_ack, acc_zero, acc_sign;
  logic [15:0] ir_in;
  logic        mem_req, mem_we, ir_load, pc_inc, pc_load, CI, acc_update;
  logic        busy, halted, err_timeout;
  logic [1:0]  sel_A;
  logic [2:0]  sel_B;
  logic [15:0] instr_cnt;
`ifdef ILLEGAL_TRAP_EN
  logic        illegal_op;
`endif
  int checks = 0;
  int errors = 0;

  ctrl_seq #(.IR_W(16), .TIMEOUT_CYC(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .ir_in(ir_in), .mem_ack(mem_ack),
    .acc_zero(acc_zero), .acc_sign(acc_sign), .mem_req(mem_req), .mem_we(mem_we),
    .ir_load(ir_load), .pc_inc(pc_inc), .pc_load(pc_load), .sel_A(sel_A), .sel_B(sel_B),
    .CI(CI), .acc_update(acc_update), .busy(busy), .halted(halted),
    .err_timeout(err_timeout), .instr_cnt(instr_cnt)
`ifdef ILLEGAL_TRAP_EN
    , .illegal_op(illegal_op)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; mem_ack = 1'b0; acc_zero = 1'b0; acc_sign = 1'b0; ir_in = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Entered in FETCH; leaves in DECODE after 'waits' unacknowledged cycles and one ack cycle
  task automatic fetch(input logic [15:0] instr, input int waits);
    for (int i = 0; i < waits; i++) begin
      mem_ack = 1'b0;
      #1;
      checks++;
      if ({mem_req, mem_we, ir_load, pc_inc} !== 4'b1000) begin
        $display("FAIL fetch_wait%0d req/we/ld/inc=%b exp 1000", i, {mem_req, mem_we, ir_load, pc_inc});
        errors++;
      end
      tick();
    end
    ir_in = instr; mem_ack = 1'b1;
    #1;
    checks++;
    if ({mem_req, mem_we, ir_load, pc_inc} !== 4'b1011) begin
      $display("FAIL fetch_ack req/we/ld/inc=%b exp 1011", {mem_req, mem_we, ir_load, pc_inc});
      errors++;
    end
    tick();
    mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({mem_req, mem_we, ir_load, pc_inc, pc_load, acc_update, CI, busy, halted, err_timeout} !== 10'b0) begin
      $display("FAIL reset_ctrls got %b exp 0", {mem_req, mem_we, ir_load, pc_inc, pc_load, acc_update, CI, busy, halted, err_timeout});
      errors++;
    end
    checks++;
    if ({sel_A, sel_B, instr_cnt} !== {2'd3, 3'd7, 16'd0}) begin
      $display("FAIL reset_sel_cnt A=%0d B=%0d cnt=%0d exp 3 7 0", sel_A, sel_B, instr_cnt);
      errors++;
    end
  endtask

  task automatic test_fetch_exec();
    do_start();
    fetch(16'h2000, 2);
    checks++;
    if ({busy, mem_req, acc_update, ir_load} !== 4'b1000) begin
      $display("FAIL decode_quiet busy/req/upd/ld=%b exp 1000", {busy, mem_req, acc_update, ir_load});
      errors++;
    end
    tick();
    checks++;
    if ({sel_A, sel_B, CI, acc_update, pc_load} !== {2'd1, 3'd0, 1'b0, 1'b1, 1'b0}) begin
      $display("FAIL exec_add A=%0d B=%0d CI=%b upd=%b pcl=%b exp 1 0 0 1 0", sel_A, sel_B, CI, acc_update, pc_load);
      errors++;
    end
    tick();
    checks++;
    if (instr_cnt !== 16'd1) begin
      $display("FAIL cnt_after_add got %0d exp 1", instr_cnt);
      errors++;
    end
  endtask

  task automatic test_branch();
    for (int k = 0; k < 2; k++) begin
      fetch(16'hC800, 0);
      tick();
      acc_zero = (k == 1);
      #1;
      checks++;
      if ({sel_A, sel_B, pc_load} !== {2'd2, 3'd3, (k == 1)}) begin
        $display("FAIL branch_z%0d A=%0d B=%0d pcl=%b exp 2 3 %0d", k, sel_A, sel_B, pc_load, k);
        errors++;
      end
      tick();
      acc_zero = 1'b0;
    end
    checks++;
    if (instr_cnt !== 16'd3) begin
      $display("FAIL cnt_after_branch got %0d exp 3", instr_cnt);
      errors++;
    end
  endtask

  task automatic test_mem();
    fetch(16'hA000, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      mem_ack = (i == 4);
      #1;
      checks++;
      if ({mem_req, mem_we, acc_update, sel_A, sel_B} !== {1'b1, 1'b1, 1'b0, 2'd1, 3'd4}) begin
        $display("FAIL mem_cyc%0d req/we/upd/A/B=%b exp 11001100", i, {mem_req, mem_we, acc_update, sel_A, sel_B});
        errors++;
      end
      tick();
    end
    mem_ack = 1'b0;
    #1;
    checks++;
    if ({mem_req, mem_we, instr_cnt} !== {1'b1, 1'b0, 16'd4}) begin
      $display("FAIL mem_done req=%b we=%b cnt=%0d exp 1 0 4", mem_req, mem_we, instr_cnt);
      errors++;
    end
  endtask

  task automatic test_alu();
    logic [15:0] instr [4];
    logic [6:0]  exp   [4];
    instr = '{16'h4000, 16'h7400, 16'h0000, 16'h1C00};
    exp   = '{{2'd1, 3'd1, 2'b11}, {2'd0, 3'd2, 2'b10}, {2'd0, 3'd4, 2'b01}, {2'd0, 3'd4, 2'b00}};
    for (int i = 0; i < 4; i++) begin
      fetch(instr[i], 0);
      tick();
      checks++;
      if ({sel_A, sel_B, CI, acc_update} !== exp[i]) begin
        $display("FAIL alu_%h A/B/CI/upd=%b exp %b", instr[i], {sel_A, sel_B, CI, acc_update}, exp[i]);
        errors++;
      end
      tick();
    end
    checks++;
    if (instr_cnt !== 16'd8) begin
      $display("FAIL cnt_after_alu got %0d exp 8", instr_cnt);
      errors++;
    end
  endtask

  task automatic test_timeout_ack();
    fetch(16'h2000, 7);
    checks++;
    if ({err_timeout, halted, busy} !== 3'b001) begin
      $display("FAIL ack_at_limit err/halt/busy=%b exp 001", {err_timeout, halted, busy});
      errors++;
    end
    tick(); tick();
    checks++;
    if (instr_cnt !== 16'd9) begin
      $display("FAIL cnt_after_limit_ack got %0d exp 9", instr_cnt);
      errors++;
    end
  endtask

  task automatic test_halt();
    fetch(16'hFC00, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      start = (i != 1);
      tick();
    end
    start = 1'b0;
    checks++;
    if ({halted, busy, mem_req, err_timeout, instr_cnt} !== {4'b1000, 16'd10}) begin
      $display("FAIL halt_hold h/b/req/err=%b cnt=%0d exp 1000 10", {halted, busy, mem_req, err_timeout}, instr_cnt);
      errors++;
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({halted, busy, instr_cnt} !== {2'b00, 16'd0}) begin
      $display("FAIL halt_rst h/b=%b cnt=%0d exp 00 0", {halted, busy}, instr_cnt);
      errors++;
    end
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_timeout();
    do_reset();
    do_start();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({mem_req, err_timeout, halted} !== 3'b100) begin
        $display("FAIL to_wait%0d req/err/halt=%b exp 100", i, {mem_req, err_timeout, halted});
        errors++;
      end
      tick();
    end
    checks++;
    if ({mem_req, err_timeout, halted, busy, instr_cnt} !== {4'b0110, 16'd0}) begin
      $display("FAIL to_fire req/err/halt/busy=%b cnt=%0d exp 0110 0", {mem_req, err_timeout, halted, busy}, instr_cnt);
      errors++;
    end
  endtask

  task automatic test_illegal();
    do_reset();
    do_start();
    fetch(16'h8000, 0);
    tick();
`ifdef ILLEGAL_TRAP_EN
    checks++;
    if ({illegal_op, halted, instr_cnt} !== {2'b11, 16'd0}) begin
      $display("FAIL illegal_trap ill/halt=%b cnt=%0d exp 11 0", {illegal_op, halted}, instr_cnt);
      errors++;
    end
`else
    checks++;
    if ({sel_A, sel_B, CI, acc_update, pc_load, mem_req, busy} !== {2'd3, 3'd7, 5'b00001}) begin
      $display("FAIL illegal_nop A=%0d B=%0d ctl=%b exp 3 7 00001", sel_A, sel_B, {CI, acc_update, pc_load, mem_req, busy});
      errors++;
    end
    tick();
    checks++;
    if (instr_cnt !== 16'd1) begin
      $display("FAIL illegal_cnt got %0d exp 1", instr_cnt);
      errors++;
    end
`endif
  endtask

  task automatic test_rst_midreq();
    do_reset();
    do_start();
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if ({mem_req, busy, instr_cnt} !== {2'b00, 16'd0}) begin
      $display("FAIL rst_midreq req/busy=%b cnt=%0d exp 00 0", {mem_req, busy}, instr_cnt);
      errors++;
    end
    tick();
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fetch_exec();
    test_branch();
    test_mem();
    test_alu();
    test_timeout_ack();
    test_halt();
    test_timeout();
    test_illegal();
    test_rst_midreq();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ctrl_seq.md
Name: ctrl_seq

Overview:
- Multi-cycle control sequencer for the accumulator CPU; successor to the combinational opcode decoder.
- Runs the FETCH/DECODE/EXEC/MEM loop and owns the memory request/acknowledge handshake.
- Drives the same ALU operand-select, carry-in, accumulator-write and branch controls.
- Adds an instruction-width parameter, a timeout watchdog, a retired-instruction counter and a HALT state.

Parameters:
IR_W, 16, instruction register width; opcode = ir_q[IR_W-1:IR_W-6]; IR_W >= 6
TIMEOUT_CYC, 255, max cycles waiting for mem_ack before error; 0 disables watchdog
CNT_W, 16, width of retired-instruction counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
start  in  1  leave IDLE and begin fetching
ir_in  in  IR_W  instruction word from memory, valid with mem_ack in FETCH
mem_ack  in  1  memory completes current request
acc_zero  in  1  accumulator == 0
acc_sign  in  1  accumulator MSB
mem_req  out  1  memory request, held until ack
mem_we  out  1  1 = write (store), 0 = read (fetch)
ir_load  out  1  pulse: instruction captured
pc_inc  out  1  pulse: PC += 1
pc_load  out  1  pulse: PC <= ALU result (branch taken)
sel_A  out  2  ALU A select (shared DI/acc/pc/x codes)
sel_B  out  3  ALU B select (shared DI/~DI/~acc/C/zero/x codes)
CI  out  1  ALU carry-in
acc_update  out  1  accumulator write enable
busy  out  1  state != IDLE and != HALT
halted  out  1  in HALT
err_timeout  out  1  sticky watchdog error
instr_cnt  out  CNT_W  retired-instruction count, wraps at 2^CNT_W

Behaviour:
- Reset (async): state=IDLE, ir_q=0, wait counter=0, instr_cnt=0, err_timeout=0. All outputs 0; sel_A/sel_B = x codes.
- State, ir_q and counters are registered. Control outputs are decoded from state and ir_q; ir_load and pc_inc also use mem_ack.
- IDLE: all controls 0. start=1 -> FETCH next cycle.
- FETCH: mem_req=1, mem_we=0.
  - On mem_ack: ir_load=1 and pc_inc=1 in the same cycle; ir_q<=ir_in; -> DECODE.
  - Minimum fetch is 1 cycle (ack on the first request cycle).
- DECODE (1 cycle, no controls asserted):
  - 101000 or 101001 -> MEM.
  - 111111 -> HALT.
  - Any other opcode -> EXEC.
- EXEC (1 cycle): drive controls from opcode, then instr_cnt++ and -> FETCH.
  - 0000xx: A=DI, B=zero, CI=0, upd=1.
  - 0001xx: same as 0000xx, upd=0.
  - 0010xx: A=acc, B=DI, CI=0, upd=1.
  - 0011xx: same as 0010xx, upd=0.
  - 0100xx: A=acc, B=~DI, CI=1, upd=1.
  - 0101xx: same as 0100xx, upd=0.
  - 0110xx: A=DI, B=~acc, CI=1, upd=1.
  - 0111xx: same as 0110xx, upd=0.
  - 101100: A=acc, B=zero, pc_load=1.
  - 110000: A=pc, B=C, pc_load=1.
  - 110010: A=pc, B=C, pc_load=acc_zero.
  - 110001: A=pc, B=C, pc_load=acc_sign.
  - Undefined opcodes: no-op (all controls 0, x selects); still counted.
- MEM: mem_req=1, mem_we=1, A=acc, B=zero, upd=0. On mem_ack: instr_cnt++ and -> FETCH.
- HALT: halted=1, all other controls 0. Exit only via rst; start is ignored. The HALT instruction is counted on entry.
- Watchdog (TIMEOUT_CYC>0):
  - Counter clears on entry to FETCH or MEM and increments each cycle without ack.
  - When the counter reaches TIMEOUT_CYC with no ack: err_timeout<=1, -> HALT.
  - mem_ack in the same cycle as the limit wins: normal transition, no error.
- mem_ack outside FETCH/MEM is ignored.
- start asserted while busy is ignored.
- rst mid-request drops mem_req asynchronously; no partial instr_cnt update.

Optional Feature:
ILLEGAL_TRAP_EN
- Defined: an undefined opcode in DECODE sets sticky output illegal_op=1 and goes to HALT. The opcode is not counted as retired.
- Undefined: the illegal_op port is absent and undefined opcodes execute as the counted no-op described above.

Test Plan:
- rst, start, FETCH ack after 2 waits with ir_in opcode 001000 -> 3 FETCH cycles, ir_load/pc_inc pulse once; EXEC: sel_A=acc, sel_B=DI, CI=0, acc_update=1; instr_cnt=1.
- Opcode 110010 with acc_zero=0, then again with acc_zero=1 -> pc_load 0 then 1; sel_A=pc, sel_B=C both times.
- Opcode 101000, MEM ack after 4 cycles -> mem_we=1 for 5 cycles, acc_update=0; back to FETCH, instr_cnt+1.
- TIMEOUT_CYC=8, no ack in FETCH -> err_timeout=1 and halted=1 after 8 cycles; with ack on cycle 8 instead -> no error.
- Opcode 111111 -> halted=1, busy=0, start pulses ignored; rst returns IDLE with instr_cnt=0.
- Opcode 100000 -> counted no-op (instr_cnt+1); with ILLEGAL_TRAP_EN -> illegal_op=1, halted=1, instr_cnt unchanged.
